data_path: RTL and testbench

// 32-bit single-bus CPU datapath (SRC-style) driven cycle-by-cycle by an external control unit.

---
 rtl/data_path_if.sv | 31 +++
 rtl/data_path.sv | 211 +++++++++++++++++++++
 tb/tb_data_path.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/data_path_if.sv
// Control-unit strobes, selects and external data feeding the SRC-style datapath.
interface data_path_if;
    logic        PCout, Zlowout, MDRout, HIout, LOout, InPortout, OutPortout;
    logic        Cout, Zhighout, BAout, Rout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic        Zhighin, Zlowin, InPortin, OutPortin, Rin, CONin;
    logic        read, write, IncPc;
    logic [1:0]  mdr_read;
    logic [3:0]  control;
    logic        GRA, GRB, GRC;
    logic [31:0] Immediate;
    logic [31:0] InportData;

    modport master (
        output PCout, Zlowout, MDRout, HIout, LOout, InPortout, OutPortout,
               Cout, Zhighout, BAout, Rout,
               MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
               Zhighin, Zlowin, InPortin, OutPortin, Rin, CONin,
               read, write, IncPc, mdr_read, control, GRA, GRB, GRC,
               Immediate, InportData
    );

    modport slave (
        input  PCout, Zlowout, MDRout, HIout, LOout, InPortout, OutPortout,
               Cout, Zhighout, BAout, Rout,
               MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
               Zhighin, Zlowin, InPortin, OutPortin, Rin, CONin,
               read, write, IncPc, mdr_read, control, GRA, GRB, GRC,
               Immediate, InportData
    );
endinterface

// File: rtl/data_path.sv
// 32-bit single-bus SRC datapath: register file, special registers, 512x32 RAM,
// ALU and CON flip-flop, sequenced one micro-step per clock by an external control unit.
module data_path (
    input  logic               clk,
    input  logic               reset,
    data_path_if.slave         ctl,
    output logic [31:0]        R0Val, R1Val, R2Val, R3Val, R4Val, R5Val, R6Val, R7Val,
    output logic [31:0]        R8Val, R9Val, R10Val, R11Val, R12Val, R13Val, R14Val, R15Val,
    output logic [31:0]        IRval, MDRval, YVal, PCVal, MAR_D,
    output logic [31:0]        bus,
    output logic [31:0]        mux_data_out,
    output logic [31:0]        R0TempOut,
    output logic [31:0]        C_sign_extended,
    output logic [31:0]        InPort_D, OutPort_D,
    output logic [31:0]        mdatain,
    output logic [31:0]        ZVal1, ZVal2,
    output logic [31:0]        ALUVal_D1, ALUVal_D2,
    output logic [15:0]        Rin_Select, Rout_Select,
    output logic               Branch
);
    localparam int unsigned W      = 32;
    localparam int unsigned NREG   = 16;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned AW     = 9;

    logic [W-1:0] gpr [NREG];
    logic [W-1:0] pc, ir, mar, mdr, y, hi, lo, inport, outport, z_hi, z_lo;
    logic         con;
    logic [W-1:0] mem [DEPTH];

    logic [3:0]   idx;
    logic [15:0]  dec;
    logic [W-1:0] alu_hi, alu_lo;
    logic         cond;

    // Register-field select from IR
    always_comb begin
        idx = 4'd0;
        if (ctl.GRA)      idx = ir[26:23];
        else if (ctl.GRB) idx = ir[22:19];
        else if (ctl.GRC) idx = ir[18:15];
        dec         = 16'(1) << idx;
        Rin_Select  = dec & {16{ctl.Rin}};
        Rout_Select = dec & {16{ctl.Rout | ctl.BAout}};
    end

    assign C_sign_extended = {{13{ir[18]}}, ir[18:0]};

    // Priority bus mux; R0 reads as zero under BAout for base-address use.
    // OutPort readback sits below every other source.
    always_comb begin
        logic found;
        bus   = '0;
        found = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (!found && Rout_Select[i]) begin
                bus   = (i == 0) ? (gpr[0] & ~{W{ctl.BAout}}) : gpr[i];
                found = 1'b1;
            end
        end
        if (!found) begin
            if (ctl.HIout)           bus = hi;
            else if (ctl.LOout)      bus = lo;
            else if (ctl.Zhighout)   bus = z_hi;
            else if (ctl.Zlowout)    bus = z_lo;
            else if (ctl.PCout)      bus = pc;
            else if (ctl.MDRout)     bus = mdr;
            else if (ctl.InPortout)  bus = inport;
            else if (ctl.Cout)       bus = C_sign_extended;
            else if (ctl.OutPortout) bus = outport;
        end
    end

    assign mdatain = ctl.read ? mem[mar[AW-1:0]] : '0;

    always_comb begin
        unique case (ctl.mdr_read)
            2'b00:   mux_data_out = bus;
            2'b01:   mux_data_out = mdatain;
            2'b10:   mux_data_out = ctl.Immediate;
            default: mux_data_out = '0;
        endcase
    end

    // ALU: A = Y, B = bus
    always_comb begin
        logic [2*W-1:0] dbl;
        logic [2*W-1:0] prod;
        logic [4:0]     sh;
        alu_hi = '0;
        alu_lo = '0;
        dbl    = '0;
        prod   = '0;
        sh     = bus[4:0];
        if (ctl.IncPc) begin
            alu_lo = bus + W'(1);
        end else begin
            case (ctl.control)
                4'd0:  alu_lo = y + bus;
                4'd1:  alu_lo = y - bus;
                4'd2:  alu_lo = y & bus;
                4'd3:  alu_lo = y | bus;
                4'd4:  alu_lo = y >> sh;
                4'd5:  alu_lo = W'($signed(y) >>> sh);
                4'd6:  alu_lo = y << sh;
                4'd7: begin
                    dbl    = {y, y} >> sh;
                    alu_lo = dbl[W-1:0];
                end
                4'd8: begin
                    dbl    = {y, y} << sh;
                    alu_lo = dbl[2*W-1:W];
                end
                4'd9: begin
                    prod   = 64'($signed({{W{y[W-1]}}, y}) * $signed({{W{bus[W-1]}}, bus}));
                    alu_hi = prod[2*W-1:W];
                    alu_lo = prod[W-1:0];
                end
                4'd10: begin
                    if (bus != '0) begin
                        alu_hi = W'($signed(y) % $signed(bus));
                        alu_lo = W'($signed(y) / $signed(bus));
                    end
                end
                4'd11: alu_lo = W'(0) - bus;
                4'd12: alu_lo = ~bus;
                default: alu_lo = bus;
            endcase
        end
    end

    assign ALUVal_D1 = alu_hi;
    assign ALUVal_D2 = alu_lo;

    always_comb begin
        unique case (ir[20:19])
            2'b00:   cond = (bus == '0);
            2'b01:   cond = (bus != '0);
            2'b10:   cond = ~bus[W-1];
            default: cond = bus[W-1];
        endcase
    end

    // Architectural registers; reset overrides every enable
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
            pc      <= '0;
            ir      <= '0;
            mar     <= '0;
            mdr     <= '0;
            y       <= '0;
            hi      <= '0;
            lo      <= '0;
            inport  <= '0;
            outport <= '0;
            z_hi    <= '0;
            z_lo    <= '0;
            con     <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (Rin_Select[i]) gpr[i] <= bus;
            end
            if (ctl.PCin)                  pc      <= bus;
            if (ctl.IRin)                  ir      <= bus;
            if (ctl.MARin)                 mar     <= bus;
            if (ctl.MDRin)                 mdr     <= mux_data_out;
            if (ctl.Yin)                   y       <= bus;
            if (ctl.HIin)                  hi      <= bus;
            if (ctl.LOin)                  lo      <= bus;
            if (ctl.InPortin)              inport  <= ctl.InportData;
            if (ctl.OutPortin)             outport <= bus;
            if (ctl.Zin || ctl.Zhighin)    z_hi    <= alu_hi;
            if (ctl.Zin || ctl.Zlowin)     z_lo    <= alu_lo;
            if (ctl.CONin)                 con     <= cond;
        end
    end

    // RAM contents survive reset; only the write strobe is masked
    always_ff @(posedge clk) begin
        if (ctl.write && !reset) mem[mar[AW-1:0]] <= mdr;
    end

    assign R0Val  = gpr[0];
    assign R1Val  = gpr[1];
    assign R2Val  = gpr[2];
    assign R3Val  = gpr[3];
    assign R4Val  = gpr[4];
    assign R5Val  = gpr[5];
    assign R6Val  = gpr[6];
    assign R7Val  = gpr[7];
    assign R8Val  = gpr[8];
    assign R9Val  = gpr[9];
    assign R10Val = gpr[10];
    assign R11Val = gpr[11];
    assign R12Val = gpr[12];
    assign R13Val = gpr[13];
    assign R14Val = gpr[14];
    assign R15Val = gpr[15];
    assign R0TempOut = gpr[0];
    assign IRval     = ir;
    assign MDRval    = mdr;
    assign YVal      = y;
    assign PCVal     = pc;
    assign MAR_D     = mar;
    assign InPort_D  = inport;
    assign OutPort_D = outport;
    assign ZVal1     = z_hi;
    assign ZVal2     = z_lo;
    assign Branch    = con;
endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: reset, port/MDR loads, fetch sequence, BAout, CON
// and a table of hand-computed ALU vectors.
module tb_data_path;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    data_path_if ctl();

    logic [31:0] r_val [16];
    logic [31:0] IRval, MDRval, YVal, PCVal, MAR_D, bus, mux_data_out, R0TempOut;
    logic [31:0] C_sign_extended, InPort_D, OutPort_D, mdatain, ZVal1, ZVal2;
    logic [31:0] ALUVal_D1, ALUVal_D2;
    logic [15:0] Rin_Select, Rout_Select;
    logic        Branch;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] IRW = 32'h0180_0005;

    data_path dut (
        .clk(clk), .reset(reset), .ctl(ctl),
        .R0Val(r_val[0]),   .R1Val(r_val[1]),   .R2Val(r_val[2]),   .R3Val(r_val[3]),
        .R4Val(r_val[4]),   .R5Val(r_val[5]),   .R6Val(r_val[6]),   .R7Val(r_val[7]),
        .R8Val(r_val[8]),   .R9Val(r_val[9]),   .R10Val(r_val[10]), .R11Val(r_val[11]),
        .R12Val(r_val[12]), .R13Val(r_val[13]), .R14Val(r_val[14]), .R15Val(r_val[15]),
        .IRval(IRval), .MDRval(MDRval), .YVal(YVal), .PCVal(PCVal), .MAR_D(MAR_D),
        .bus(bus), .mux_data_out(mux_data_out), .R0TempOut(R0TempOut),
        .C_sign_extended(C_sign_extended), .InPort_D(InPort_D), .OutPort_D(OutPort_D),
        .mdatain(mdatain), .ZVal1(ZVal1), .ZVal2(ZVal2),
        .ALUVal_D1(ALUVal_D1), .ALUVal_D2(ALUVal_D2),
        .Rin_Select(Rin_Select), .Rout_Select(Rout_Select), .Branch(Branch)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        inc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } alu_vec_t;

    alu_vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        ctl.PCout = 0; ctl.Zlowout = 0; ctl.MDRout = 0; ctl.HIout = 0; ctl.LOout = 0;
        ctl.InPortout = 0; ctl.OutPortout = 0; ctl.Cout = 0; ctl.Zhighout = 0;
        ctl.BAout = 0; ctl.Rout = 0; ctl.MARin = 0; ctl.Zin = 0; ctl.PCin = 0;
        ctl.MDRin = 0; ctl.IRin = 0; ctl.Yin = 0; ctl.HIin = 0; ctl.LOin = 0;
        ctl.Zhighin = 0; ctl.Zlowin = 0; ctl.InPortin = 0; ctl.OutPortin = 0;
        ctl.Rin = 0; ctl.CONin = 0; ctl.read = 0; ctl.write = 0; ctl.IncPc = 0;
        ctl.mdr_read = 2'b00; ctl.control = 4'd0; ctl.GRA = 0; ctl.GRB = 0; ctl.GRC = 0;
    endtask

    task automatic load_inport(input logic [31:0] v);
        ctl.InportData = v;
        ctl.InPortin   = 1;
        tick();
        clear_ctl();
    endtask

    initial begin
        vecs[0]  = '{"add",      32'd7,          32'd5,          4'd0,  1'b0, 32'h0,        32'd12};
        vecs[1]  = '{"add_wrap", 32'hFFFF_FFFF,  32'd2,          4'd0,  1'b0, 32'h0,        32'd1};
        vecs[2]  = '{"sub",      32'd5,          32'd7,          4'd1,  1'b0, 32'h0,        32'hFFFF_FFFE};
        vecs[3]  = '{"and",      32'hF0F0_F0F0,  32'hFF00_FF00,  4'd2,  1'b0, 32'h0,        32'hF000_F000};
        vecs[4]  = '{"or",       32'h0000_000F,  32'h0000_00F0,  4'd3,  1'b0, 32'h0,        32'h0000_00FF};
        vecs[5]  = '{"shr",      32'h8000_0000,  32'd4,          4'd4,  1'b0, 32'h0,        32'h0800_0000};
        vecs[6]  = '{"shra",     32'h8000_0000,  32'd4,          4'd5,  1'b0, 32'h0,        32'hF800_0000};
        vecs[7]  = '{"shl",      32'd1,          32'd31,         4'd6,  1'b0, 32'h0,        32'h8000_0000};
        vecs[8]  = '{"ror",      32'd1,          32'd1,          4'd7,  1'b0, 32'h0,        32'h8000_0000};
        vecs[9]  = '{"rol",      32'h8000_0001,  32'd4,          4'd8,  1'b0, 32'h0,        32'h0000_0018};
        vecs[10] = '{"mul_neg",  32'hFFFF_FFFE,  32'd3,          4'd9,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[11] = '{"mul_big",  32'h0001_0000,  32'h0001_0000,  4'd9,  1'b0, 32'h1,        32'h0};
        vecs[12] = '{"div",      32'd17,         32'd5,          4'd10, 1'b0, 32'd2,        32'd3};
        vecs[13] = '{"div_neg",  32'hFFFF_FFF9,  32'd2,          4'd10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[14] = '{"div_zero", 32'd5,          32'd0,          4'd10, 1'b0, 32'h0,        32'h0};
        vecs[15] = '{"neg",      32'd0,          32'd5,          4'd11, 1'b0, 32'h0,        32'hFFFF_FFFB};
        vecs[16] = '{"not",      32'd0,          32'd0,          4'd12, 1'b0, 32'h0,        32'hFFFF_FFFF};
        vecs[17] = '{"pass",     32'd99,         32'h0000_1234,  4'd13, 1'b0, 32'h0,        32'h0000_1234};
        vecs[18] = '{"incpc",    32'd3,          32'hFFFF_FFFF,  4'd1,  1'b1, 32'h0,        32'h0};

        clear_ctl();
        ctl.Immediate  = '0;
        ctl.InportData = '0;

        // Reset state
        reset = 1;
        tick();
        reset = 0;
        check("rst_pc", PCVal, 32'h0);
        check("rst_ir", IRval, 32'h0);
        check("rst_mar", MAR_D, 32'h0);
        for (int i = 0; i < 16; i++) check($sformatf("rst_r%0d", i), r_val[i], 32'h0);
        check("rst_zhi", ZVal1, 32'h0);
        check("rst_zlo", ZVal2, 32'h0);
        check("rst_branch", 32'(Branch), 32'h0);

        // InPort, MDR immediate, PC/MAR load from MDR
        load_inport(32'd16);
        check("inport", InPort_D, 32'd16);
        ctl.Immediate = 32'd15; ctl.mdr_read = 2'b10; ctl.MDRin = 1;
        tick(); clear_ctl();
        check("mdr_imm", MDRval, 32'd15);
        ctl.MDRout = 1; ctl.PCin = 1; ctl.MARin = 1;
        tick(); clear_ctl();
        check("pc_load", PCVal, 32'd15);

        // Place the instruction word at mem[15]
        ctl.Immediate = IRW; ctl.mdr_read = 2'b10; ctl.MDRin = 1;
        tick(); clear_ctl();
        ctl.write = 1;
        tick(); clear_ctl();
        ctl.read = 1; #1;
        check("ram_read", mdatain, IRW);
        ctl.read = 0; #1;
        check("ram_noread", mdatain, 32'h0);

        // Fetch T0..T3
        ctl.PCout = 1; ctl.MARin = 1; ctl.IncPc = 1; ctl.Zlowin = 1;
        tick(); clear_ctl();
        check("t0_mar", MAR_D, 32'd15);
        check("t0_zlo", ZVal2, 32'd16);
        check("t0_zhi", ZVal1, 32'd0);
        ctl.Zlowout = 1; ctl.PCin = 1; ctl.read = 1; ctl.mdr_read = 2'b01; ctl.MDRin = 1;
        tick(); clear_ctl();
        check("t1_pc", PCVal, 32'd16);
        check("t1_mdr", MDRval, IRW);
        ctl.MDRout = 1; ctl.IRin = 1;
        tick(); clear_ctl();
        check("t2_ir", IRval, IRW);
        check("c_sext", C_sign_extended, 32'h0000_0005);
        ctl.GRA = 1; ctl.Rin = 1; ctl.InPortout = 1; #1;
        check("t3_rin_sel", 32'(Rin_Select), 32'h0000_0008);
        tick(); clear_ctl();
        check("t3_r3", r_val[3], 32'd16);

        // BAout gating of R0 (Rb field of IRW is 0)
        load_inport(32'd9);
        ctl.GRB = 1; ctl.Rin = 1; ctl.InPortout = 1;
        tick(); clear_ctl();
        check("r0_load", r_val[0], 32'd9);
        ctl.GRB = 1; ctl.BAout = 1; #1;
        check("bus_baout", bus, 32'h0);
        clear_ctl();
        ctl.GRB = 1; ctl.Rout = 1; #1;
        check("bus_rout", bus, 32'd9);
        clear_ctl(); #1;
        check("bus_idle", bus, 32'h0);
        ctl.InPortout = 1; ctl.PCout = 1; #1;
        check("bus_prio", bus, 32'd16);
        clear_ctl();

        // CON with IR[20:19]=00
        ctl.GRB = 1; ctl.BAout = 1; ctl.CONin = 1;
        tick(); clear_ctl();
        check("con_zero", 32'(Branch), 32'h1);
        load_inport(32'd4);
        ctl.InPortout = 1; ctl.CONin = 1;
        tick(); clear_ctl();
        check("con_nonzero", 32'(Branch), 32'h0);

        // ALU table: Y then B through InPort
        foreach (vecs[k]) begin
            load_inport(vecs[k].a);
            ctl.InPortout = 1; ctl.Yin = 1;
            tick(); clear_ctl();
            load_inport(vecs[k].b);
            ctl.InPortout = 1; ctl.control = vecs[k].op; ctl.IncPc = vecs[k].inc; ctl.Zin = 1;
            tick(); clear_ctl();
            check({vecs[k].name, "_hi"}, ZVal1, vecs[k].exp_hi);
            check({vecs[k].name, "_lo"}, ZVal2, vecs[k].exp_lo);
        end

        // Reset beats enables; RAM keeps its contents
        ctl.InPortout = 1; ctl.PCin = 1; reset = 1;
        tick(); clear_ctl(); reset = 0;
        check("rst_prio_pc", PCVal, 32'h0);
        load_inport(32'd15);
        ctl.InPortout = 1; ctl.MARin = 1;
        tick(); clear_ctl();
        ctl.read = 1; #1;
        check("ram_kept", mdatain, IRW);
        clear_ctl();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
